// File: rtl/div_fx_sat.sv
// Iterative signed fixed-point divider with rounding, saturation, and divide-by-zero/overflow flags.
// Latency: out_valid rises NSTEP+3 edges after the accepting edge, for any operand values.
// Backpressure: one operation in flight; result held in DONE until out_ready; in_ready only in IDLE.
//
// Ports: clk/rst (async active-low), in_valid/in_ready + a, b, rnd_mode operand handshake,
//        out_valid/out_ready + q, dbz, ovf result handshake.
module div_fx_sat #(
    parameter int IN_WIDTH  = 26,
    parameter int FBITS     = 9,
    parameter int OUT_WIDTH = 14,
    parameter int BPC       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  a,
    input  logic [IN_WIDTH-1:0]  b,
    input  logic                 rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] q,
    output logic                 dbz,
    output logic                 ovf
);
    localparam int ITER  = IN_WIDTH - 1 + FBITS;
    localparam int NSTEP = ITER / BPC;
    localparam int CW    = $clog2(NSTEP + 1);

    generate
        if ((BPC != 1 && BPC != 2) || (ITER % BPC != 0)) begin : g_bad_bpc
            $error("div_fx_sat: BPC must be 1 or 2 and must divide ITER");
        end
    endgenerate

    // Largest positive magnitude, at the width of the rounded quotient.
    localparam logic [ITER:0]        MAXP_M = {{(ITER + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] Q_MAXP = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] Q_MINN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_CALC, S_ROUND, S_SAT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]    ma_q, ma_d, mb_q, mb_d;
    logic                   sneg_q, sneg_d, aneg_q, aneg_d, mode_q, mode_d;
    logic [ITER-1:0]        sh_q, sh_d;
    logic [IN_WIDTH-1:0]    rem_q, rem_d;
    logic                   big_q, big_d;
    logic [ITER:0]          mag_q, mag_d;
    logic [OUT_WIDTH-1:0]   qo_q, qo_d;
    logic                   dbz_q, dbz_d, ovf_q, ovf_d;

    // |a| << FBITS is one bit wider than the shifter; its top bit is resolved in INIT.
    logic [ITER:0] num;
    assign num = {ma_q, {FBITS{1'b0}}};

    // BPC restoring steps; the shifter feeds dividend bits out the top and takes quotient bits in at the bottom.
    logic [IN_WIDTH-1:0] rem_s;
    logic [ITER-1:0]     sh_s;
    logic [IN_WIDTH:0]   trial;
    always_comb begin
        rem_s = rem_q;
        sh_s  = sh_q;
        trial = '0;
        for (int i = 0; i < BPC; i++) begin
            trial = {rem_s, sh_s[ITER-1]};
            if (trial >= {1'b0, mb_q}) begin
                trial = trial - {1'b0, mb_q};
                sh_s  = {sh_s[ITER-2:0], 1'b1};
            end else begin
                sh_s  = {sh_s[ITER-2:0], 1'b0};
            end
            rem_s = trial[IN_WIDTH-1:0];
        end
    end

    // Round half to even: compare twice the remainder against the divisor.
    logic [IN_WIDTH:0] two_r;
    logic              rnd_up;
    assign two_r  = {rem_q, 1'b0};
    assign rnd_up = !mode_q && ((two_r > {1'b0, mb_q}) || ((two_r == {1'b0, mb_q}) && sh_q[0]));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sneg_d  = sneg_q;
        aneg_d  = aneg_q;
        mode_d  = mode_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        big_d   = big_q;
        mag_d   = mag_q;
        qo_d    = qo_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ma_d    = a[IN_WIDTH-1] ? (~a + 1'b1) : a;
                    mb_d    = b[IN_WIDTH-1] ? (~b + 1'b1) : b;
                    sneg_d  = a[IN_WIDTH-1] ^ b[IN_WIDTH-1];
                    aneg_d  = a[IN_WIDTH-1];
                    mode_d  = rnd_mode;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                sh_d  = num[ITER-1:0];
                // The top numerator bit only produces a quotient bit when |b| is 1; that quotient
                // is far beyond any output range, so it is kept as a sticky saturation flag.
                big_d = num[ITER] && (mb_q == IN_WIDTH'(1));
                rem_d = IN_WIDTH'(num[ITER] && (mb_q != IN_WIDTH'(1)));
                mag_d = '0;
                cnt_d = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                rem_d = rem_s;
                sh_d  = sh_s;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NSTEP - 1)) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                mag_d   = {1'b0, sh_q} + (ITER + 1)'(rnd_up);
                state_d = S_SAT;
            end
            S_SAT: begin
                dbz_d = (mb_q == '0);
                ovf_d = 1'b0;
                if (mb_q == '0) begin
                    if (ma_q == '0)  qo_d = '0;
                    else if (aneg_q) qo_d = Q_MINN;
                    else             qo_d = Q_MAXP;
                end else if (mag_q == '0 && !big_q) begin
                    qo_d = '0;
                end else if (!sneg_q) begin
                    if (big_q || mag_q > MAXP_M) begin
                        qo_d  = Q_MAXP;
                        ovf_d = 1'b1;
                    end else begin
                        qo_d  = mag_q[OUT_WIDTH-1:0];
                    end
                end else begin
                    if (big_q || mag_q > MAXP_M + 1'b1) begin
                        qo_d  = Q_MINN;
                        ovf_d = 1'b1;
                    end else begin
                        qo_d  = '0 - mag_q[OUT_WIDTH-1:0];
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sneg_q  <= 1'b0;
            aneg_q  <= 1'b0;
            mode_q  <= 1'b0;
            sh_q    <= '0;
            rem_q   <= '0;
            big_q   <= 1'b0;
            mag_q   <= '0;
            qo_q    <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sneg_q  <= sneg_d;
            aneg_q  <= aneg_d;
            mode_q  <= mode_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            big_q   <= big_d;
            mag_q   <= mag_d;
            qo_q    <= qo_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // in_ready drops immediately while reset is asserted, not just after the next edge.
    assign in_ready  = rst && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = qo_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_fx_sat.sv
module tb_div_fx_sat;
    localparam int IW   = 26;
    localparam int FB   = 9;
    localparam int OW   = 14;
    localparam int LAT1 = 37;
    localparam int LAT2 = 20;
    localparam longint MAXP = (longint'(1) << (OW - 1)) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, out_ready, rnd_mode;
    logic [IW-1:0] a, b;
    logic          in_ready1, out_valid1, dbz1, ovf1;
    logic          in_ready2, out_valid2, dbz2, ovf2;
    logic [OW-1:0] q1, q2;

    div_fx_sat #(.IN_WIDTH(IW), .FBITS(FB), .OUT_WIDTH(OW), .BPC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid1), .out_ready(out_ready),
        .q(q1), .dbz(dbz1), .ovf(ovf1));

    div_fx_sat #(.IN_WIDTH(IW), .FBITS(FB), .OUT_WIDTH(OW), .BPC(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid2), .out_ready(out_ready),
        .q(q2), .dbz(dbz2), .ovf(ovf2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: exact integer quotient of |a|*2^FBITS by |b|, then rounding, sign and clamping.
    function automatic void model(input logic [IW-1:0] av, input logic [IW-1:0] bv, input logic mode,
                                  output logic [OW-1:0] qe, output logic dbze, output logic ovfe);
        longint sa, sb, ma, mb, m, r, v;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        dbze = (mb == 0);
        ovfe = 1'b0;
        if (mb == 0) begin
            v = (sa > 0) ? MAXP : ((sa < 0) ? -(MAXP + 1) : 0);
        end else begin
            m = (ma << FB) / mb;
            r = (ma << FB) % mb;
            if (!mode && ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1)))) m++;
            if ((sa < 0) != (sb < 0)) begin
                if (m > MAXP + 1) begin v = -(MAXP + 1); ovfe = 1'b1; end
                else v = -m;
            end else begin
                if (m > MAXP) begin v = MAXP; ovfe = 1'b1; end
                else v = m;
            end
        end
        qe = v[OW-1:0];
    endfunction

    function automatic logic [IW-1:0] rnd_val();
        logic [IW-1:0] v;
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return '0;
        if (sel == 1) return {1'b1, {(IW-1){1'b0}}};
        v = IW'($urandom) >> $urandom_range(0, IW - 1);
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // One operation on both divider instances in lockstep; poke drives in_valid mid-calculation,
    // hold keeps out_ready low for that many cycles after both results are up.
    task automatic run_op(input logic [IW-1:0] av, input logic [IW-1:0] bv, input logic mode,
                          input logic [OW-1:0] qe, input logic dbze, input logic ovfe,
                          input bit poke, input int hold, input string tag);
        int l1, l2;
        @(negedge clk);
        chk({tag, " ready"}, {in_ready1, in_ready2}, 2'b11);
        a = av; b = bv; rnd_mode = mode; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = IW'($urandom); b = IW'($urandom); rnd_mode = ~mode;
        l1 = 0; l2 = 0;
        for (int k = 1; k <= 80 && (l1 == 0 || l2 == 0); k++) begin
            in_valid = (poke && k >= 3 && k <= 10);
            @(posedge clk); #1;
            if (poke && k == 10) chk({tag, " busy ready"}, {in_ready1, in_ready2}, 2'b00);
            if (l1 == 0 && out_valid1) l1 = k;
            if (l2 == 0 && out_valid2) l2 = k;
        end
        in_valid = 1'b0;
        chk({tag, " lat1"}, l1, LAT1);
        chk({tag, " lat2"}, l2, LAT2);
        chk({tag, " q1"}, q1, qe);
        chk({tag, " q2"}, q2, qe);
        chk({tag, " flags"}, {dbz1, ovf1, dbz2, ovf2}, {dbze, ovfe, dbze, ovfe});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " hold"}, {out_valid1, out_valid2, in_ready1, in_ready2, q1, q2, dbz1, ovf1, dbz2, ovf2},
                {1'b1, 1'b1, 1'b0, 1'b0, qe, qe, dbze, ovfe, dbze, ovfe});
        end
        // Offer new operands on the release edge: they must not be taken from DONE.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk({tag, " release"}, {out_valid1, out_valid2, in_ready1, in_ready2}, 4'b0011);
    endtask

    typedef struct {
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        logic          mode;
        logic [OW-1:0] q;
        logic          dbz;
        logic          ovf;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [OW-1:0] qe;
        logic de, oe;
        logic [IW-1:0] ra, rb;
        logic rm;
        bit seen;

        tbl[0]  = '{IW'(1536),        IW'(1024),        1'b0, 14'h0300, 1'b0, 1'b0};
        tbl[1]  = '{IW'(-1536),       IW'(1024),        1'b0, 14'h3D00, 1'b0, 1'b0};
        tbl[2]  = '{IW'(512),         IW'(1536),        1'b0, 14'd171,  1'b0, 1'b0};
        tbl[3]  = '{IW'(512),         IW'(1536),        1'b1, 14'd170,  1'b0, 1'b0};
        tbl[4]  = '{IW'(3),           IW'(1024),        1'b0, 14'd2,    1'b0, 1'b0};
        tbl[5]  = '{IW'(3),           IW'(1024),        1'b1, 14'd1,    1'b0, 1'b0};
        tbl[6]  = '{IW'(5),           IW'(1024),        1'b0, 14'd2,    1'b0, 1'b0};
        tbl[7]  = '{IW'(10240),       IW'(512),         1'b0, 14'h1FFF, 1'b0, 1'b1};
        tbl[8]  = '{IW'(-8192),       IW'(512),         1'b0, 14'h2000, 1'b0, 1'b0};
        tbl[9]  = '{IW'(-(1 << 25)),  IW'(-(1 << 25)),  1'b0, 14'd512,  1'b0, 1'b0};
        tbl[10] = '{IW'(512),         IW'(0),           1'b0, 14'h1FFF, 1'b1, 1'b0};
        tbl[11] = '{IW'(-512),        IW'(0),           1'b0, 14'h2000, 1'b1, 1'b0};
        tbl[12] = '{IW'(0),           IW'(0),           1'b0, 14'h0000, 1'b1, 1'b0};
        tbl[13] = '{IW'(-3),          IW'(1024),        1'b0, 14'h3FFE, 1'b0, 1'b0};
        tbl[14] = '{IW'(-1),          IW'(4096),        1'b0, 14'h0000, 1'b0, 1'b0};
        tbl[15] = '{IW'(-(1 << 25)),  IW'(1),           1'b1, 14'h2000, 1'b0, 1'b1};
        tbl[16] = '{IW'(-8193),       IW'(512),         1'b0, 14'h2000, 1'b0, 1'b1};
        tbl[17] = '{IW'(7),           IW'(-1024),       1'b0, 14'h3FFC, 1'b0, 1'b0};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_mode = 1'b0; a = '0; b = '0;
        #2;
        chk("reset outputs", {in_ready1, in_ready2, out_valid1, out_valid2, q1, q2, dbz1, ovf1, dbz2, ovf2}, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready after reset", {in_ready1, in_ready2, out_valid1, out_valid2}, 4'b1100);

        for (int i = 0; i < 18; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].q, tbl[i].dbz, tbl[i].ovf,
                   (i == 1), (i == 0) ? 10 : 0, $sformatf("vec%0d", i));
        end

        // Abort an operation with reset in the middle of the calculation.
        @(negedge clk);
        a = IW'(1536); b = IW'(1024); rnd_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid reset outputs", {in_ready1, in_ready2, out_valid1, out_valid2, q1, q2, dbz1, dbz2}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid reset release", {in_ready1, in_ready2, out_valid1, out_valid2}, 4'b1100);
        seen = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid2 || !in_ready1 || !in_ready2) seen = 1'b1;
        end
        chk("aborted op silent", seen, 1'b0);
        run_op(IW'(1536), IW'(1024), 1'b0, 14'h0300, 1'b0, 1'b0, 1'b0, 0, "after reset");

        for (int i = 0; i < 40; i++) begin
            ra = rnd_val();
            rb = rnd_val();
            rm = 1'($urandom_range(0, 1));
            model(ra, rb, rm, qe, de, oe);
            run_op(ra, rb, rm, qe, de, oe, 1'b0, 0, $sformatf("rnd%0d a=%0h b=%0h m=%0d", i, ra, rb, rm));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_fx_sat.md
Name: div_fx_sat

Overview:
- Iterative signed fixed-point divider for the SE_BLOCK datapath. Next generation of the existing sequential divider.
- Adds valid/ready handshakes on both sides, a configurable number of quotient bits per cycle, and a per-operation rounding mode.
- Saturates the result to the output width instead of truncating it, and flags divide-by-zero and overflow.
- Sits between the SE accumulators and the scale/activation stage; one division in flight at a time.

Parameters:
- IN_WIDTH, 26, width of signed two's-complement dividend and divisor.
- FBITS, 9, fractional bits of both inputs and of the output.
- OUT_WIDTH, 14, width of signed quotient output (FBITS fractional bits).
- BPC, 1, quotient bits resolved per CALC cycle. Legal values are 1 or 2. ITER % BPC must equal 0; violation is an elaboration error.
- Derived: ITER = IN_WIDTH-1+FBITS; NSTEP = ITER/BPC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  IN_WIDTH  signed dividend.
- b  in  IN_WIDTH  signed divisor.
- rnd_mode  in  1  0 = round half to even, 1 = truncate toward zero.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- q  out  OUT_WIDTH  signed quotient, FBITS fractional bits.
- dbz  out  1  divisor was zero, valid with out_valid.
- ovf  out  1  result saturated, valid with out_valid.

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. Outputs: in_ready=0 while rst is low, 1 in IDLE after release; out_valid=0; q=0; dbz=0; ovf=0. Any operation in progress is aborted with no output.
- States: IDLE, INIT, CALC, ROUND, SAT, DONE.
  - IDLE: in_ready=1. On in_valid, latch a, b, rnd_mode, sign difference and magnitudes, then go to INIT.
  - Magnitudes are IN_WIDTH bits unsigned, so |-2^(IN_WIDTH-1)| is exact.
  - INIT: load accumulator and shifter; go to CALC.
  - CALC: restoring division, BPC bits per cycle, for exactly NSTEP cycles, then go to ROUND.
  - ROUND: compute the rounded magnitude; go to SAT.
  - SAT: apply sign and saturation; register q, dbz, ovf; set out_valid=1; go to DONE.
  - DONE: hold q, dbz, ovf and out_valid stable until out_ready=1. On that edge out_valid goes to 0 and the state returns to IDLE.
- in_ready is 1 only in IDLE. Operands are not accepted during DONE, even if out_ready is high on the same cycle.
- Latency is fixed: out_valid rises on the (NSTEP+3)th rising edge after the accepting edge. Defaults: 37 edges for BPC=1, 20 for BPC=2. Latency is independent of operand values, including b=0.
- Arithmetic: raw magnitude M = floor(|a|*2^FBITS/|b|), remainder R.
  - rnd_mode=0: M+1 if 2R>|b|, or if 2R==|b| and M is odd.
  - rnd_mode=1: M unchanged.
- Sign and saturation, with MAXP = 2^(OUT_WIDTH-1)-1:
  - Positive result: if magnitude > MAXP, q=MAXP and ovf=1.
  - Negative result: if magnitude > MAXP+1, q=-(MAXP+1) and ovf=1; otherwise q = two's complement of the magnitude.
  - A zero magnitude always gives q=0, never negative zero.
- Divide by zero (b=0): dbz=1, ovf=0.
  - a>0: q=MAXP.
  - a<0: q=-(MAXP+1).
  - a=0: q=0.
- No internal state survives into the next operation. Every operation reloads all of its datapath registers.

Test Plan:
- Defaults, BPC=1. a=1536 (3.0), b=1024 (2.0), rnd_mode=0 -> q=768 (0x0300), dbz=0, ovf=0. out_valid rises exactly 37 edges after accept.
- a=-1536, b=1024 -> q=0x3D00 (-768). a=512, b=1536 -> q=171 with rnd_mode=0, q=170 with rnd_mode=1.
- Tie cases: a=3, b=1024 (raw 1.5) -> q=2 with mode 0, q=1 with mode 1. a=5, b=1024 (raw 2.5) -> q=2 with mode 0.
- Saturation:
  - a=10240, b=512 -> q=0x1FFF, ovf=1.
  - a=-8192, b=512 -> q=0x2000, ovf=0.
  - a=-2^25, b=-2^25 -> q=512, ovf=0.
- Divide by zero:
  - a=512, b=0 -> q=0x1FFF, dbz=1.
  - a=-512, b=0 -> q=0x2000, dbz=1.
  - a=0, b=0 -> q=0, dbz=1.
  - Latency is still 37 edges in every case.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles after out_valid -> q, dbz, ovf stable and in_ready=0 throughout.
  - Drive in_valid during CALC -> ignored.
  - Pull rst low mid-CALC -> out_valid=0 and in_ready=1 after release. The next operation gives the correct result.
  - Repeat the first scenario with BPC=2 -> same q, latency 20 edges.
